// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states, exception
// cause codes and default reset/vector addresses.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_EXT      = 2'd1,
        CAUSE_MISALIGN = 2'd2
    } exc_cause_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/npc_sel.sv
// Next-PC selection for a retiring instruction: redirect priority plus the
// misaligned-target check that turns a bad redirect into an exception.
module npc_sel import fetch_pkg::*; #(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic [31:0] pc,
    input  logic [31:0] epc,
    input  logic        exc,
    input  logic        eret,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] npc,
    output logic        take_exc,
    output exc_cause_t  cause
);

    logic [31:0] target;
    logic        redirect;

    always_comb begin
        redirect = 1'b1;
        target   = pc + 32'd4;
        if (eret) begin
            target = epc;
        end else if (jmp) begin
            target = jmp_target;
        end else if (br_taken) begin
            target = br_target;
        end else begin
            redirect = 1'b0;
        end

        npc      = target;
        take_exc = 1'b0;
        cause    = CAUSE_NONE;
        // The sequential pc+4 path is never checked for alignment, only redirects.
        if (exc) begin
            npc      = EXC_VECTOR;
            take_exc = 1'b1;
            cause    = CAUSE_EXT;
        end else if (redirect && misaligned(target)) begin
            npc      = EXC_VECTOR;
            take_exc = 1'b1;
            cause    = CAUSE_MISALIGN;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: IDLE/REQ/EXEC sequencing, instruction latch, exception PC
// capture and retired-instruction counter.
module fetch_ctrl import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] npc,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        exc,
    input  logic        eret,
    output logic [31:0] epc,
    output logic [1:0]  exc_cause,
    output logic [31:0] retired
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         retire;
    logic [31:0]  sel_npc;
    logic         sel_exc;
    exc_cause_t   sel_cause;

    npc_sel #(.EXC_VECTOR(EXC_VECTOR)) u_npc_sel (
        .pc         (pc),
        .epc        (epc),
        .exc        (exc),
        .eret       (eret),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .npc        (sel_npc),
        .take_exc   (sel_exc),
        .cause      (sel_cause)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        pc_en       = 1'b0;
        retire      = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                // An external exception forces retirement even under stall.
                if (!stall || exc) begin
                    retire    = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_addr = pc;
    assign npc = reset ? RESET_PC : ((state == EXEC) ? sel_npc : pc + 32'd4);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr     <= '0;
            epc       <= '0;
            exc_cause <= '0;
            retired   <= '0;
        end else begin
            if (state == REQ && imem_ack) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                if (sel_exc) begin
                    epc       <= pc;
                    exc_cause <= sel_cause;
                end else begin
                    retired <= retired + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table followed by
// randomized transactions checked against a transaction-level reference model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic [1:0]  exc_cause;
    logic [31:0] retired;

    always #5 clock = ~clock;

    fetch_ctrl #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_VEC)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .npc         (npc),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .exc         (exc),
        .eret        (eret),
        .epc         (epc),
        .exc_cause   (exc_cause),
        .retired     (retired)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [31:0] m_epc;
    logic [1:0]  m_cause;
    logic [31:0] m_retired;

    typedef struct {
        logic [31:0] pc;
        int unsigned dly;
        int unsigned stl;
        bit          rstall;
        bit          exc;
        bit          eret;
        bit          jmp;
        bit          br;
        logic [31:0] jt;
        logic [31:0] bt;
        logic [31:0] exp_npc;
        logic [1:0]  exp_cause;
        logic [31:0] exp_epc;
        bit          exp_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] npc;
        bit          is_exc;
        logic [1:0]  cause;
    } ref_t;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Architectural rule: exception beats everything, then eret/jmp/branch, else
    // fall through; any redirect that is not word-aligned becomes an exception.
    function automatic ref_t ref_next(input logic [31:0] cur_pc, input logic [31:0] cur_epc,
                                      input bit e, input bit r, input bit j, input logic [31:0] jt,
                                      input bit b, input logic [31:0] bt);
        ref_t        res;
        logic [31:0] dest;
        bit          redirected;
        res.is_exc = 1'b0;
        res.cause  = 2'd0;
        if (e) begin
            res.npc    = EXC_VEC;
            res.is_exc = 1'b1;
            res.cause  = 2'd1;
            return res;
        end
        redirected = 1'b1;
        if (r)      dest = cur_epc;
        else if (j) dest = jt;
        else if (b) dest = bt;
        else begin
            redirected = 1'b0;
            dest       = cur_pc + 32'd4;
        end
        if (redirected && (dest % 4) != 0) begin
            res.npc    = EXC_VEC;
            res.is_exc = 1'b1;
            res.cause  = 2'd2;
        end else begin
            res.npc = dest;
        end
        return res;
    endfunction

    task automatic clear_ctl();
        stall    = 1'b0;
        exc      = 1'b0;
        eret     = 1'b0;
        jmp      = 1'b0;
        br_taken = 1'b0;
        imem_ack = 1'b0;
    endtask

    // Runs one full fetch/execute/retire transaction; entered just after a
    // rising edge with the DUT waiting in the request phase.
    task automatic run_instr(input vec_t v);
        logic [31:0] rd;
        clear_ctl();
        pc         = v.pc;
        jmp_target = v.jt;
        br_target  = v.bt;
        for (int unsigned i = 0; i < v.dly; i++) begin
            imem_ack = 1'b0;
            #1;
            check1("req_wait", imem_req, 1'b1);
            check32("addr_wait", imem_addr, v.pc);
            check1("valid_wait", instr_valid, 1'b0);
            check1("pc_en_wait", pc_en, 1'b0);
            check32("npc_wait", npc, v.pc + 32'd4);
            @(posedge clock); #1;
        end
        rd         = $urandom;
        imem_rdata = rd;
        imem_ack   = 1'b1;
        #1;
        check1("req_ack", imem_req, 1'b1);
        check32("addr_ack", imem_addr, v.pc);
        @(posedge clock); #1;
        imem_ack = 1'b0;
        check32("instr", instr, rd);
        check1("valid_exec", instr_valid, 1'b1);
        check1("req_exec", imem_req, 1'b0);
        for (int unsigned i = 0; i < v.stl; i++) begin
            stall      = 1'b1;
            eret       = v.eret;
            jmp        = v.jmp;
            br_taken   = v.br;
            imem_ack   = ($urandom % 2) == 1;
            imem_rdata = $urandom;
            #1;
            check1("pc_en_stall", pc_en, 1'b0);
            check1("req_stall", imem_req, 1'b0);
            @(posedge clock); #1;
            check32("instr_stall", instr, rd);
            check1("valid_stall", instr_valid, 1'b1);
            check32("epc_stall", epc, m_epc);
            check32("retired_stall", retired, m_retired);
        end
        stall    = v.rstall;
        exc      = v.exc;
        eret     = v.eret;
        jmp      = v.jmp;
        br_taken = v.br;
        imem_ack = 1'b0;
        #1;
        check1("pc_en_retire", pc_en, 1'b1);
        check32("npc_retire", npc, v.exp_npc);
        @(posedge clock); #1;
        clear_ctl();
        m_epc     = v.exp_epc;
        m_cause   = v.exp_cause;
        m_retired = m_retired + (v.exp_cnt ? 32'd1 : 32'd0);
        check32("epc", epc, m_epc);
        check32("exc_cause", {30'b0, exc_cause}, {30'b0, m_cause});
        check32("retired", retired, m_retired);
        check1("pc_en_after", pc_en, 1'b0);
        check1("req_after", imem_req, 1'b1);
        check1("valid_after", instr_valid, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_req"}, imem_req, 1'b0);
        check1({tag, "_pc_en"}, pc_en, 1'b0);
        check1({tag, "_valid"}, instr_valid, 1'b0);
        check32({tag, "_instr"}, instr, 32'h0);
        check32({tag, "_epc"}, epc, 32'h0);
        check32({tag, "_cause"}, {30'b0, exc_cause}, 32'h0);
        check32({tag, "_retired"}, retired, 32'h0);
        check32({tag, "_npc"}, npc, RST_PC);
    endtask

    vec_t tbl[11];

    initial begin
        vec_t        v;
        ref_t        r;
        logic [31:0] t;

        tbl[0]  = '{32'h0000_3000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                    32'h0000_3004, 2'd0, 32'h0, 1'b1};
        tbl[1]  = '{32'h0000_3010, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                    32'h0000_3014, 2'd0, 32'h0, 1'b1};
        tbl[2]  = '{32'h0000_3014, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3100, 32'h0000_3200,
                    32'h0000_3100, 2'd0, 32'h0, 1'b1};
        tbl[3]  = '{32'h0000_3020, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                    32'h0000_4180, 2'd1, 32'h0000_3020, 1'b0};
        tbl[4]  = '{32'h0000_4180, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
                    32'h0000_3020, 2'd1, 32'h0000_3020, 1'b1};
        tbl[5]  = '{32'h0000_3024, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_3102,
                    32'h0000_4180, 2'd2, 32'h0000_3024, 1'b0};
        tbl[6]  = '{32'hFFFF_FFFC, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                    32'h0000_0000, 2'd2, 32'h0000_3024, 1'b1};
        tbl[7]  = '{32'h0000_3030, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3101, 32'h0,
                    32'h0000_4180, 2'd2, 32'h0000_3030, 1'b0};
        tbl[8]  = '{32'h0000_3040, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_3200,
                    32'h0000_3200, 2'd2, 32'h0000_3030, 1'b1};
        tbl[9]  = '{32'h0000_3044, 0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3300, 32'h0000_3400,
                    32'h0000_3030, 2'd2, 32'h0000_3030, 1'b1};
        tbl[10] = '{32'h0000_3048, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3101, 32'h0,
                    32'h0000_4180, 2'd1, 32'h0000_3048, 1'b0};

        reset      = 1'b1;
        pc         = 32'h0000_1234;
        imem_rdata = 32'h0;
        jmp_target = 32'h0;
        br_target  = 32'h0;
        clear_ctl();
        m_epc     = 32'h0;
        m_cause   = 2'd0;
        m_retired = 32'h0;
        #1;
        check_reset_values("reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset    = 1'b0;
        imem_ack = 1'b1;
        #1;
        check1("idle_req", imem_req, 1'b0);
        check1("idle_valid", instr_valid, 1'b0);
        @(posedge clock); #1;
        check32("idle_ack_ignored", instr, 32'h0);
        check1("req_after_idle", imem_req, 1'b1);
        imem_ack = 1'b0;

        for (int unsigned k = 0; k < 11; k++) begin
            run_instr(tbl[k]);
        end

        for (int unsigned k = 0; k < 200; k++) begin
            v.pc = ($urandom % 16 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            v.dly    = $urandom % 4;
            v.stl    = $urandom % 3;
            v.exc    = ($urandom % 8) == 0;
            v.rstall = v.exc ? (($urandom % 2) == 1) : 1'b0;
            v.eret   = ($urandom % 6) == 0;
            v.jmp    = ($urandom % 5) == 0;
            v.br     = ($urandom % 3) == 0;
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 4 == 0) t = t | (32'd1 + ($urandom % 3));
            v.jt = t;
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 4 == 0) t = t | (32'd1 + ($urandom % 3));
            v.bt = t;
            r = ref_next(v.pc, m_epc, v.exc, v.eret, v.jmp, v.jt, v.br, v.bt);
            v.exp_npc   = r.npc;
            v.exp_cause = r.is_exc ? r.cause : m_cause;
            v.exp_epc   = r.is_exc ? v.pc : m_epc;
            v.exp_cnt   = !r.is_exc;
            run_instr(v);
        end

        pc       = 32'h0000_3050;
        imem_ack = 1'b0;
        @(posedge clock); #1;
        check1("req_before_abort", imem_req, 1'b1);
        reset = 1'b1;
        #1;
        check_reset_values("abort");
        imem_ack = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check1("abort_idle_req", imem_req, 1'b0);
        @(posedge clock); #1;
        check32("abort_ack_ignored", instr, 32'h0);
        check1("abort_req_again", imem_req, 1'b1);
        imem_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, value driven on npc during and after reset.
REQ-002 Parameter EXC_VECTOR, 32'h0000_4180, exception handler entry address.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 pc  in  32  current PC from the program-counter register.
REQ-006 npc  out  32  next PC presented to the program-counter register.
REQ-007 pc_en  out  1  one-cycle strobe; the PC register loads npc only when high.
REQ-008 imem_req, imem_addr  out  1, 32  instruction fetch request and address (= pc).
REQ-009 imem_ack, imem_rdata  in  1, 32  fetch completion and instruction word.
REQ-010 instr, instr_valid  out  32, 1  latched instruction and its valid flag.
REQ-011 stall  in  1  downstream hold; instruction not retired while high.
REQ-012 br_taken, br_target  in  1, 32  conditional branch redirect.
REQ-013 jmp, jmp_target  in  1, 32  unconditional jump redirect.
REQ-014 exc, eret  in  1, 1  external exception request; return from exception.
REQ-015 epc, exc_cause  out  32, 2  saved exception PC; cause (0 none, 1 external, 2 misaligned target).
REQ-016 retired  out  32  count of retired instructions.

Function
REQ-017 FSM states IDLE, REQ, EXEC; IDLE -> REQ unconditionally one cycle after reset release.
REQ-018 REQ: imem_req=1, imem_addr=pc; on imem_ack, instr <= imem_rdata, -> EXEC; no ack -> stay, req held.
REQ-019 imem_ack outside REQ ignored; imem_req=0 in IDLE and EXEC.
REQ-020 EXEC: instr_valid=1; in all other states instr_valid=0.
REQ-021 EXEC with stall=1 and exc=0: hold state, pc_en=0, all registers unchanged.
REQ-022 EXEC retire (stall=0 or exc=1): pc_en=1 for exactly one cycle, -> REQ.
REQ-023 npc priority on retire: exc -> EXEC_VECTOR; eret -> epc; jmp -> jmp_target; br_taken -> br_target; else pc+4.
REQ-024 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no fault.
REQ-025 Selected jmp/br/eret target with bits[1:0]!=0: treated as exception, npc=EXC_VECTOR, exc_cause=2.
REQ-026 On any exception retire: epc <= pc, exc_cause updated (1 external, 2 misaligned); otherwise epc/exc_cause hold.
REQ-027 exc overrides stall; eret, jmp, br_taken ignored while stall=1.
REQ-028 retired increments by 1 on each non-exception retire; wraps at 2^32; exception retires not counted.
REQ-029 Latency: minimum 2 cycles per instruction (REQ with immediate ack, then EXEC).
REQ-030 npc combinational from current inputs in EXEC; equals pc+4 outside EXEC with pc_en=0.

Reset
REQ-031 While reset high: state=IDLE, imem_req=0, pc_en=0, instr_valid=0, instr=0, epc=0, exc_cause=0, retired=0, npc=RESET_PC.
REQ-032 Reset mid-fetch or mid-stall aborts immediately; pending imem_ack after release is ignored until REQ.

Structure
REQ-033 State encoding, cause codes, and RESET_PC/EXC_VECTOR defaults in shared package fetch_pkg.
REQ-034 Next-PC mux and misalignment check in one combinational sub-module npc_sel; FSM, epc and counter in fetch_ctrl.

Verification
REQ-035 Reset release, ack same cycle as req -> imem_addr=32'h0000_3000, instr_valid next cycle, pc_en with npc=32'h0000_3004.
REQ-036 pc=32'h0000_3010, ack delayed 3 cycles, stall 2 cycles -> imem_req held 4 cycles, pc_en only after stall drops, retired +1.
REQ-037 EXEC with jmp=1 and br_taken=1, jmp_target=32'h0000_3100 -> npc=32'h0000_3100.
REQ-038 exc=1 with stall=1 at pc=32'h0000_3020 -> npc=32'h0000_4180, epc=32'h0000_3020, exc_cause=1, retired unchanged; then eret -> npc=32'h0000_3020.
REQ-039 br_target=32'h0000_3102 taken -> npc=32'h0000_4180, exc_cause=2; pc=32'hFFFF_FFFC sequential -> npc=0.
REQ-040 Assert reset during REQ wait -> imem_req falls same cycle, all outputs at REQ-031 values.
